// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: pixel type, default image
// geometry and the row-major tap numbering of the 3x3 window.
package sobel_pkg;

    localparam int PIX_W_DEFAULT      = 8;
    localparam int IMG_WIDTH_DEFAULT  = 640;
    localparam int IMG_HEIGHT_DEFAULT = 480;

    typedef logic [PIX_W_DEFAULT-1:0] pix_t;

    // Window taps, row-major: top row oldest line, left column oldest pixel.
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;
    localparam int NUM_TAPS = 9;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row delay line: the output is the pixel accepted DEPTH enables ago.
// Storage is deliberately not reset; the window generator masks stale rows.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEFAULT,
    parameter int WIDTH = PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift the whole line one place on every accepted pixel, holding otherwise.
    always_ff @(posedge clk) begin
        if (en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood for the Sobel filter.
// Two chained line buffers supply the two rows above the incoming pixel; a
// 3x3 register window shifts in one column per accepted pixel, and row/column
// counters flag only windows that lie fully inside the current frame.
// Optional macro FRAME_DONE_EN adds a frame_done pulse after the last pixel.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT,
    parameter int PIX_W      = PIX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refresh,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic             win_valid,
    output logic [PIX_W-1:0] win0,
    output logic [PIX_W-1:0] win1,
    output logic [PIX_W-1:0] win2,
    output logic [PIX_W-1:0] win3,
    output logic [PIX_W-1:0] win4,
    output logic [PIX_W-1:0] win5,
    output logic [PIX_W-1:0] win6,
    output logic [PIX_W-1:0] win7,
    output logic [PIX_W-1:0] win8
`ifdef FRAME_DONE_EN
    ,
    output logic             frame_done
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] a_out;
    logic [PIX_W-1:0] b_out;
    logic [PIX_W-1:0] win [NUM_TAPS];
    logic             col_wrap;
    logic             row_wrap;
    logic             interior;

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_line_a (
        .clk  (clk),
        .en   (pix_valid),
        .din  (pix_in),
        .dout (a_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_line_b (
        .clk  (clk),
        .en   (pix_valid),
        .din  (a_out),
        .dout (b_out)
    );

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    // Two full rows and two columns of the current row are needed before a window is real.
    assign interior = (row >= RW'(2)) && (col >= CW'(2));

    // Track the raster position of the next pixel; a refresh with a pixel makes it (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (refresh) begin
            col <= pix_valid ? CW'(1) : '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Shift the new column {line B, line A, incoming pixel} in on the right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                win[i] <= '0;
            end
        end else if (refresh) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                win[i] <= '0;
            end
            if (pix_valid) begin
                win[TAP_TR] <= b_out;
                win[TAP_MR] <= a_out;
                win[TAP_BR] <= pix_in;
            end
        end else if (pix_valid) begin
            win[TAP_TL] <= win[TAP_TC];
            win[TAP_TC] <= win[TAP_TR];
            win[TAP_TR] <= b_out;
            win[TAP_ML] <= win[TAP_MC];
            win[TAP_MC] <= win[TAP_MR];
            win[TAP_MR] <= a_out;
            win[TAP_BL] <= win[TAP_BC];
            win[TAP_BC] <= win[TAP_BR];
            win[TAP_BR] <= pix_in;
        end
    end

    // One-cycle valid pulse for each accepted pixel that completes an in-frame window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid <= 1'b0;
        end else begin
            win_valid <= pix_valid && !refresh && interior;
        end
    end

`ifdef FRAME_DONE_EN
    // Pulse once after the bottom-right pixel of the frame, unless a refresh lands on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_valid && !refresh && row_wrap && col_wrap;
        end
    end
`endif

    assign win0 = win[TAP_TL];
    assign win1 = win[TAP_TC];
    assign win2 = win[TAP_TR];
    assign win3 = win[TAP_ML];
    assign win4 = win[TAP_MC];
    assign win5 = win[TAP_MR];
    assign win6 = win[TAP_BL];
    assign win7 = win[TAP_BC];
    assign win8 = win[TAP_BR];

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Upstream stage of sobelfilter. Converts a raster-order 8-bit pixel stream into a 3x3 neighbourhood, presented on win0..win8. These outputs connect one-to-one to sobelfilter in0..in8. Internally uses two row-delay line buffers plus a 3x3 register window, with row/column counters to gate border positions.

Parameters:
IMG_WIDTH, 640, pixels per row (>=3)
IMG_HEIGHT, 480, rows per frame (>=3)
PIX_W, 8, pixel width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
refresh  input  1  synchronous start-of-frame; clears counters/window, same signal driven to sobelfilter
pix_valid  input  1  pix_in carries a pixel this cycle
pix_in  input  PIX_W  pixel, raster order (row-major, left to right)
win_valid  output  1  win0..win8 hold a complete, in-frame 3x3 window
win0..win8  output  PIX_W each  window taps, row-major: win0 = top-left (r-2,c-2), win4 = centre (r-1,c-1), win8 = bottom-right (r,c)

Behaviour:
- Reset (rst=0, async): col/row counters=0, window regs=0, win_valid=0, win0..win8=0. Line-buffer contents need not be cleared.
- Pixel accept: every cycle with pix_valid=1. With pix_valid=0, all state holds (stall-tolerant; gaps allowed anywhere).
- Accepted pixel at (r,c):
  - Line buffer A outputs pixel (r-1,c); line buffer B outputs (r-2,c).
  - Column {B_out, A_out, pix_in} shifts into the window's right column; the left column is discarded.
- Counters: col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0. On wrap, row increments; row wraps IMG_HEIGHT-1 -> 0, which starts the next frame implicitly.
- win_valid: registered, asserted the cycle after accepting pixel (r,c) with r>=2 and c>=2; otherwise 0. Latency = 1 cycle. Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- No row wrap-around: windows straddling a row boundary (c<2) are never flagged valid.
- win_valid is a 1-cycle pulse per qualifying pixel. It drops during pix_valid=0 cycles; win0..win8 hold their last value.
- refresh=1: counters and window regs cleared, win_valid=0 next cycle. Stale line-buffer data is masked because the row count restarts.
- refresh and pix_valid in the same cycle: refresh wins; pix_in is taken as pixel (0,0) of the new frame.
- Async reset mid-frame: immediate return to reset state; the first pixel after release is (0,0).
- Widths: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits. No arithmetic on pixel data.

Optional Feature:
- Macro FRAME_DONE_EN.
- Defined: adds output frame_done (1 bit), a registered 1-cycle pulse the cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1). Reset value 0; suppressed if refresh is asserted in the same cycle.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package sobel_pkg: PIX_W default; default IMG_WIDTH/IMG_HEIGHT constants; pixel typedef pix_t; tap-index constants (TAP_TL=0 .. TAP_BR=8).
- One sub-module, sobel_line_buffer: depth-IMG_WIDTH delay line with enable (pix_valid), one data in, one data out, no reset on storage. Instantiated twice, chained A->B.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 4r+c, continuous pix_valid, rst released after 2 cycles):
- First window: pixel (2,2)=10 accepted -> next cycle win_valid=1, win0..win8 = 0,1,2,4,5,6,8,9,10. No earlier win_valid.
- Last window: pixel (3,3)=15 -> win0..win8 = 5,6,7,9,10,11,13,14,15. Exactly 4 win_valid pulses in the frame; (3,0),(3,1) produce none.
- Stall: drop pix_valid for 3 cycles between pixels 10 and 11 -> win_valid low during the gap, windows hold, next window = 1,2,3,5,6,7,9,10,11.
- Refresh mid-frame after pixel 6, then restart stream at 0 -> no win_valid until new (2,2); window equals the first-window vector.
- Async reset (rst=0) asserted after pixel 11 -> outputs 0 immediately; after release, the full-frame sequence matches the first two checks.
- FRAME_DONE_EN defined: single frame_done pulse one cycle after pixel 15; none when refresh coincides with pixel 15.
